// File: rtl/unit_arbiter.sv
// -----------------------------------------------------------------------------
// unit_arbiter
//
// Shares one execution-unit port (ALU / MEM) between NUM_THREADS thread
// sequencers. A thread with a unit request (sel != UNIT_SEL_NONE) is granted
// the shared port for exactly one transaction; the arbiter returns unit_out and
// unit_ready only to the granted thread. Threads that drive UNIT_SEL_NONE are
// never arbitrated: they see ready=1 and out=0 combinationally in every state.
//
// Handshake: a thread presents sel/in and holds them stable until it sees
// t_unit_ready=1 in the same cycle; that cycle completes its transaction. The
// shared unit completes a transaction in any cycle where unit_ready=1 while
// unit_sel != NONE.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   t_unit_sel     per-thread unit select, SEL_W bits per thread, thread 0 at LSB
//   t_unit_in      per-thread operands, 3 words per thread (word 0 at LSB)
//   t_unit_out     per-thread result, WORD_W bits per thread
//   t_unit_ready   per-thread advance strobe
//   unit_sel       select to the shared units
//   unit_in        operands to the shared units (3 words)
//   unit_out       result from the shared units
//   unit_ready     shared unit completes this cycle
//   grant_valid    high while a transaction is granted (BUSY)
//   grant_id       index of the granted thread
//   dbg_state      FSM state (0 = IDLE, 1 = BUSY)
//   dbg_rr_ptr     round-robin search start pointer
// -----------------------------------------------------------------------------
module unit_arbiter #(
   parameter int               NUM_THREADS   = 2,
   parameter int               ROUND_ROBIN   = 1,
   parameter int               TID_W         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
   parameter int               WORD_W        = 32,
   parameter int               SEL_W         = 2,
   parameter logic [SEL_W-1:0] UNIT_SEL_NONE = '0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_THREADS*SEL_W-1:0]    t_unit_sel,
   input  logic [NUM_THREADS*3*WORD_W-1:0] t_unit_in,
   output logic [NUM_THREADS*WORD_W-1:0]   t_unit_out,
   output logic [NUM_THREADS-1:0]          t_unit_ready,
   output logic [SEL_W-1:0]                unit_sel,
   output logic [3*WORD_W-1:0]             unit_in,
   input  logic [WORD_W-1:0]               unit_out,
   input  logic                            unit_ready,
   output logic                            grant_valid,
   output logic [TID_W-1:0]                grant_id,
   output logic                            dbg_state,
   output logic [TID_W-1:0]                dbg_rr_ptr
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [TID_W-1:0]  grant_id_q, grant_id_d;
   logic [TID_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [NUM_THREADS-1:0] req;
   logic [SEL_W-1:0]       gnt_sel;
   logic [3*WORD_W-1:0]    gnt_in;
   logic                   any_req;
   logic [TID_W-1:0]       winner;
   logic [TID_W-1:0]       grant_next;

   // Request vector and the granted thread's request, selected by the
   // registered grant index.
   always_comb begin
      req     = '0;
      gnt_sel = UNIT_SEL_NONE;
      gnt_in  = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         req[t] = (t_unit_sel[t*SEL_W +: SEL_W] != UNIT_SEL_NONE);
         if (grant_id_q == TID_W'(t)) begin
            gnt_sel = t_unit_sel[t*SEL_W +: SEL_W];
            gnt_in  = t_unit_in[t*3*WORD_W +: 3*WORD_W];
         end
      end
   end

   // Winner search. The "hi" pass finds the first requester at or above
   // rr_ptr; the "lo" pass finds the lowest requester overall, which is both
   // the wrap-around result and the fixed-priority result.
   always_comb begin
      logic             found_hi;
      logic             found_lo;
      logic [TID_W-1:0] win_hi;
      logic [TID_W-1:0] win_lo;
      found_hi = 1'b0;
      found_lo = 1'b0;
      win_hi   = '0;
      win_lo   = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         if (req[t]) begin
            if ((ROUND_ROBIN != 0) && (TID_W'(t) >= rr_ptr_q) && !found_hi) begin
               found_hi = 1'b1;
               win_hi   = TID_W'(t);
            end
            if (!found_lo) begin
               found_lo = 1'b1;
               win_lo   = TID_W'(t);
            end
         end
      end
      any_req = found_lo;
      winner  = found_hi ? win_hi : win_lo;
   end

   assign grant_next = (grant_id_q == TID_W'(NUM_THREADS - 1)) ? '0 : grant_id_q + TID_W'(1);

   // Next state. A transaction ends on unit completion or when the granted
   // thread withdraws its request; both advance the rotation pointer.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d    = BUSY;
               grant_id_d = winner;
            end
         end
         BUSY: begin
            if ((gnt_sel == UNIT_SEL_NONE) || unit_ready) begin
               state_d  = IDLE;
               rr_ptr_d = grant_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // Output muxing. rst gates everything so the shared unit and the threads
   // see an all-zero interface in the very cycle reset rises.
   always_comb begin
      t_unit_out   = '0;
      t_unit_ready = '0;
      unit_sel     = UNIT_SEL_NONE;
      unit_in      = '0;
      if (!rst) begin
         if (state_q == BUSY) begin
            unit_sel = gnt_sel;
            unit_in  = gnt_in;
         end
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (!req[t]) begin
               t_unit_ready[t] = 1'b1;
            end else if ((state_q == BUSY) && (grant_id_q == TID_W'(t))) begin
               t_unit_out[t*WORD_W +: WORD_W] = unit_out;
               t_unit_ready[t]                = unit_ready;
            end
         end
      end
   end

   assign grant_valid = (state_q == BUSY);
   assign grant_id    = grant_id_q;
   assign dbg_state   = state_q;
   assign dbg_rr_ptr  = rr_ptr_q;

endmodule

// File: tb/tb_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unit_arbiter
//
// Main instance: 4 threads, round-robin. Second instance: 4 threads, fixed
// priority, all threads requesting. The shared unit is modelled as an adder
// (unit_out = operand1 + operand2) so forwarded operands are visible in the
// returned result.
// -----------------------------------------------------------------------------
module tb_unit_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int SW = 2;
   localparam int TW = 2;

   localparam logic [SW-1:0] SEL_NONE = 2'd0;
   localparam logic [SW-1:0] SEL_ALU  = 2'd1;
   localparam logic [SW-1:0] SEL_MEM  = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- main DUT (round-robin) ----------------
   logic [N*SW-1:0]  t_sel;
   logic [N*3*W-1:0] t_in;
   logic [N*W-1:0]   t_out;
   logic [N-1:0]     t_rdy;
   logic [SW-1:0]    u_sel;
   logic [3*W-1:0]   u_in;
   logic [W-1:0]     u_out;
   logic             u_rdy;
   logic             gv;
   logic [TW-1:0]    gid;
   logic             dbg_st;
   logic [TW-1:0]    dbg_rr;

   assign u_out = u_in[W +: W] + u_in[2*W +: W];

   unit_arbiter #(.NUM_THREADS(N), .ROUND_ROBIN(1), .WORD_W(W), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst),
      .t_unit_sel(t_sel), .t_unit_in(t_in), .t_unit_out(t_out), .t_unit_ready(t_rdy),
      .unit_sel(u_sel), .unit_in(u_in), .unit_out(u_out), .unit_ready(u_rdy),
      .grant_valid(gv), .grant_id(gid), .dbg_state(dbg_st), .dbg_rr_ptr(dbg_rr)
   );

   // ---------------- fixed-priority DUT ----------------
   logic [N*SW-1:0]  fp_sel;
   logic [N*3*W-1:0] fp_in;
   logic [N*W-1:0]   fp_out;
   logic [N-1:0]     fp_rdy;
   logic [SW-1:0]    fp_usel;
   logic [3*W-1:0]   fp_uin;
   logic [W-1:0]     fp_uout;
   logic             fp_urdy;
   logic             fp_gv;
   logic [TW-1:0]    fp_gid;
   logic             fp_st;
   logic [TW-1:0]    fp_rr;

   assign fp_uout = fp_uin[W +: W] + fp_uin[2*W +: W];

   unit_arbiter #(.NUM_THREADS(N), .ROUND_ROBIN(0), .WORD_W(W), .SEL_W(SW)) dut_fp (
      .clk(clk), .rst(rst),
      .t_unit_sel(fp_sel), .t_unit_in(fp_in), .t_unit_out(fp_out), .t_unit_ready(fp_rdy),
      .unit_sel(fp_usel), .unit_in(fp_uin), .unit_out(fp_uout), .unit_ready(fp_urdy),
      .grant_valid(fp_gv), .grant_id(fp_gid), .dbg_state(fp_st), .dbg_rr_ptr(fp_rr)
   );

   // ---------------- stimulus state ----------------
   logic [SW-1:0] sel_a [N];
   logic [W-1:0]  in_a  [N][3];

   // ---------------- reference model state ----------------
   int m_busy;
   int m_gid;
   int m_rr;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [TW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply();
      for (int t = 0; t < N; t++) begin
         t_sel[t*SW +: SW] = sel_a[t];
         for (int j = 0; j < 3; j++) t_in[(t*3+j)*W +: W] = in_a[t][j];
      end
   endtask

   task automatic clear_inputs();
      for (int t = 0; t < N; t++) begin
         sel_a[t] = SEL_NONE;
         for (int j = 0; j < 3; j++) in_a[t][j] = '0;
      end
      u_rdy = 1'b0;
      apply();
      fp_sel  = '0;
      fp_in   = '0;
      fp_urdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      m_busy = 0;
      m_gid  = 0;
      m_rr   = 0;
      @(negedge clk);
      chk("rst_rdy", t_rdy, 0);
      chk("rst_out", t_out, 0);
      chk("rst_sel", u_sel, SEL_NONE);
      chk("rst_in", u_in, 0);
      chk("rst_gv", gv, 0);
      chk("rst_gid", gid, 0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Expected outputs from the arbitration rules, given model state and the
   // inputs currently applied.
   task automatic model_check();
      logic [N*W-1:0] e_out;
      logic [N-1:0]   e_rdy;
      logic [SW-1:0]  e_sel;
      logic [3*W-1:0] e_in;
      e_out = '0;
      e_rdy = '0;
      e_sel = SEL_NONE;
      e_in  = '0;
      for (int t = 0; t < N; t++) begin
         if (sel_a[t] == SEL_NONE) e_rdy[t] = 1'b1;
         else if (m_busy != 0 && t == m_gid) begin
            e_rdy[t] = u_rdy;
            e_out[t*W +: W] = in_a[t][1] + in_a[t][2];
         end
      end
      if (m_busy != 0) begin
         e_sel = sel_a[m_gid];
         e_in  = {in_a[m_gid][2], in_a[m_gid][1], in_a[m_gid][0]};
      end
      chk("m_rdy", t_rdy, e_rdy);
      chk("m_out", t_out, e_out);
      chk("m_usel", u_sel, e_sel);
      chk("m_uin", u_in, e_in);
      chk("m_gv", gv, (m_busy != 0));
      chk("m_st", dbg_st, (m_busy != 0));
      if (m_busy != 0) chk("m_gid", gid, m_gid);
      chk("m_rr", dbg_rr, m_rr);
   endtask

   // Transition taken at the next clock edge.
   task automatic model_advance();
      int q[$];
      if (m_busy == 0) begin
         for (int k = 0; k < N; k++) begin
            int t;
            t = (m_rr + k) % N;
            if (sel_a[t] != SEL_NONE) q.push_back(t);
         end
         if (q.size() > 0) begin
            m_busy = 1;
            m_gid  = q[0];
         end
      end else if (sel_a[m_gid] == SEL_NONE || u_rdy) begin
         m_busy = 0;
         m_rr   = (m_gid + 1) % N;
      end
   endtask

   task automatic cyc_begin();
      @(negedge clk);
      model_check();
   endtask

   task automatic cyc_end();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   // Random inputs that respect the thread-side hold rule: the granted
   // thread keeps sel/in unless it deliberately withdraws.
   task automatic rand_inputs();
      for (int t = 0; t < N; t++) begin
         if (m_busy != 0 && t == m_gid && sel_a[t] != SEL_NONE) begin
            if ($urandom_range(0, 99) < 4) sel_a[t] = SEL_NONE;
         end else begin
            int r;
            r = $urandom_range(0, 9);
            sel_a[t] = (r < 4) ? SEL_NONE : ((r < 7) ? SEL_ALU : SEL_MEM);
            for (int j = 0; j < 3; j++) in_a[t][j] = $urandom;
         end
      end
      u_rdy = ($urandom_range(0, 2) != 0);
      apply();
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   // ---------------- main sequence ----------------
   initial begin
      int cnt [N];
      int fp_cnt;

      rst = 1'b1;
      do_reset();

      // Single ALU ADD on thread 0, unit ready in the same cycle.
      sel_a[0] = SEL_ALU;
      in_a[0][0] = 32'h1; in_a[0][1] = 32'd5; in_a[0][2] = 32'd7;
      u_rdy = 1'b1;
      apply();
      cyc_begin();
      chk("t1_idle_rdy0", t_rdy[0], 0);
      chk("t1_idle_gv", gv, 0);
      cyc_end();
      cyc_begin();
      chk("t1_out0", t_out[W-1:0], 12);
      chk("t1_rdy0", t_rdy[0], 1);
      chk("t1_gid", gid, 0);
      sel_a[0] = SEL_NONE;
      apply();
      cyc_end();
      cyc_begin();
      chk("t1_rr", dbg_rr, 1);
      cyc_end();

      // MEM on thread 0 with 5-cycle unit latency; thread 1 idles on NONE.
      sel_a[0] = SEL_MEM;
      in_a[0][0] = 32'h2; in_a[0][1] = 32'd100; in_a[0][2] = 32'd23;
      u_rdy = 1'b0;
      apply();
      cyc_begin();
      chk("t4_idle_rdy1", t_rdy[1], 1);
      cyc_end();
      for (int k = 1; k <= 5; k++) begin
         u_rdy = (k == 5);
         apply();
         cyc_begin();
         chk("t4_rdy0", t_rdy[0], (k == 5));
         chk("t4_rdy1", t_rdy[1], 1);
         if (k == 5) chk("t4_out0", t_out[W-1:0], 123);
         cyc_end();
      end
      sel_a[0] = SEL_NONE;
      u_rdy = 1'b0;
      apply();

      // Thread 2 granted, then withdraws mid-transaction.
      sel_a[2] = SEL_ALU;
      in_a[2][1] = 32'd40; in_a[2][2] = 32'd2;
      apply();
      cyc_begin();
      cyc_end();
      cyc_begin();
      chk("t5_gid", gid, 2);
      chk("t5_rdy2_wait", t_rdy[2], 0);
      cyc_end();
      sel_a[2] = SEL_NONE;
      u_rdy = 1'b1;
      apply();
      cyc_begin();
      chk("t5_abort_out2", t_out[2*W +: W], 0);
      chk("t5_abort_rdy2", t_rdy[2], 1);
      cyc_end();
      cyc_begin();
      chk("t5_gv", gv, 0);
      chk("t5_rr", dbg_rr, 3);
      cyc_end();

      // Reset asserted while BUSY.
      u_rdy = 1'b0;
      sel_a[1] = SEL_ALU;
      apply();
      cyc_begin();
      cyc_end();
      cyc_begin();
      chk("t6_gid", gid, 1);
      chk("t6_gv", gv, 1);
      cyc_end();
      rst = 1'b1;
      #1;
      chk("t6_rst_sel", u_sel, SEL_NONE);
      chk("t6_rst_gv", gv, 0);
      chk("t6_rst_rdy", t_rdy, 0);
      m_busy = 0; m_gid = 0; m_rr = 0;
      sel_a[3] = SEL_ALU;
      apply();
      @(posedge clk);
      #1 rst = 1'b0;
      cyc_begin();
      cyc_end();
      cyc_begin();
      chk("t6_first_gid", gid, 1);
      cyc_end();

      // All threads requesting continuously, unit always ready.
      do_reset();
      for (int t = 0; t < N; t++) begin
         sel_a[t] = SEL_ALU;
         for (int j = 0; j < 3; j++) in_a[t][j] = $urandom;
         cnt[t] = 0;
      end
      u_rdy = 1'b1;
      apply();
      fp_sel  = {N{SEL_ALU}};
      fp_in   = {12{$urandom}};
      fp_urdy = 1'b1;
      fp_cnt  = 0;
      for (int r = 0; r < 2; r++)
         for (int t = 0; t < N; t++) exp_q.push_back(TW'(t));
      for (int c = 0; c < 16; c++) begin
         cyc_begin();
         if (gv) begin
            if (exp_q.size() == 0) chk("t2_extra_grant", gid, 0 - 1);
            else chk("t2_order", gid, exp_q.pop_front());
         end
         for (int t = 0; t < N; t++) cnt[t] += int'(t_rdy[t]);
         if (fp_gv) chk("fp_gid", fp_gid, 0);
         chk("fp_rdy_hi", fp_rdy[N-1:1], 0);
         fp_cnt += int'(fp_rdy[0]);
         cyc_end();
      end
      chk("t2_q_empty", exp_q.size(), 0);
      for (int t = 0; t < N; t++) chk("t2_rdy_count", cnt[t], 2);
      chk("fp_rdy0_count", fp_cnt, 8);

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         rand_inputs();
         cyc_begin();
         cyc_end();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/unit_arbiter.md
Name: unit_arbiter

Overview:
- Lets NUM_THREADS thread sequencers share one execution-unit port: unit_sel / unit_in / unit_out / unit_ready, covering the ALU and MEM units.
- Each thread keeps its own state and only advances on its per-thread ready.
- The arbiter picks one requesting thread, forwards that thread's request to the shared units, and returns unit_out and unit_ready to the granted thread only.
- This is the enabler for multi-hart operation of the existing single-thread sequencer.

Parameters:
- NUM_THREADS, 2, number of thread ports (>=1; a value of 1 degenerates to a registered pass-through).
- ROUND_ROBIN, 1, 1 = rotating priority; 0 = fixed priority with the lowest index winning.
- TID_W, $clog2(NUM_THREADS) (min 1), width of the grant index.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- t_unit_sel  in  NUM_THREADS x unit_sel_t  per-thread unit select; UNIT_SEL_NONE = no request
- t_unit_in  in  NUM_THREADS x unit_in_t  per-thread operands [0..2], 3 words each
- t_unit_out  out  NUM_THREADS x word_t  per-thread result
- t_unit_ready  out  NUM_THREADS  per-thread advance strobe
- unit_sel  out  unit_sel_t  to shared units
- unit_in  out  unit_in_t  to shared units
- unit_out  in  word_t  from shared units
- unit_ready  in  1  from shared units; transaction completes this cycle
- grant_valid  out  1  BUSY indicator
- grant_id  out  TID_W  currently granted thread

Behaviour:
- Reset (async, rst=1): state=IDLE, grant_id=0, grant_valid=0, rr_ptr=0. All outputs read zero, with unit_sel=UNIT_SEL_NONE. This holds even mid-transaction; the downstream unit sees NONE in the same cycle rst rises.
- No-unit steps: a thread driving UNIT_SEL_NONE receives t_unit_ready=1 and t_unit_out=0 combinationally, in every state. Such threads are never arbitrated and are never stalled.
- State IDLE:
  - unit_sel=NONE, unit_in=0, and no requesting thread sees ready.
  - If any thread requests (sel != NONE), choose a winner and go to BUSY next cycle with grant_id=winner and grant_valid=1.
  - Round-robin: first requester at or after rr_ptr, searching upward with wrap from NUM_THREADS-1 to 0.
  - Fixed priority: lowest requesting index.
- State BUSY:
  - unit_sel and unit_in are driven combinationally from t_unit_sel[grant_id] and t_unit_in[grant_id].
  - t_unit_out[grant_id] = unit_out and t_unit_ready[grant_id] = unit_ready. All other requesting threads see ready=0 and out=0.
  - On unit_ready=1: go to IDLE and set rr_ptr = grant_id+1, wrapping to 0 at NUM_THREADS. In fixed mode rr_ptr is unused.
  - If the granted thread drops to NONE while BUSY (abort): go to IDLE with no ready delivered from the unit. The NONE passthrough rule still applies, and rr_ptr advances as on completion.
- Latency: one arbitration cycle (IDLE) per unit transaction, plus the unit's own latency. A unit with combinational ready=1 gives 2 cycles per transaction.
- Back-to-back: the same thread requesting again after completion passes through IDLE first. Under round-robin, any other requester wins ahead of it.
- Simultaneous events:
  - unit_ready=1 together with new requests: completion is handled first; the new winner is chosen in the following IDLE cycle.
  - Requests arriving during BUSY wait; no thread is preempted.
- Fairness: under ROUND_ROBIN with all threads requesting continuously, each thread is granted exactly once per NUM_THREADS transactions.
- Operand stability: the granted thread must hold its sel/in stable until ready. This is a protocol rule on the thread side and is checked by the bench, not corrected by the block.
- The block adds no storage of operands; all output muxing is combinational from the registered grant_id.

Test Plan:
- Reset, then thread0 requests ALU ADD (in = {ADD, 5, 7}); unit returns 12 with ready=1 in the same cycle. Required: IDLE 1 cycle, then BUSY with t_unit_out[0]=12 and t_unit_ready[0]=1 in cycle 2, grant_id=0, rr_ptr=1.
- NUM_THREADS=4, all threads requesting continuously, ROUND_ROBIN=1, unit ready=1 every cycle. Required: grant order 0,1,2,3,0,...; each thread gets ready exactly once per 8 cycles; non-granted threads see ready=0.
- Same load with ROUND_ROBIN=0. Required: thread0 is granted every transaction and threads 1–3 never get ready while thread0 requests.
- Thread1 drives NONE while thread0 holds a MEM grant with ready delayed 5 cycles. Required: t_unit_ready[1]=1 every cycle; t_unit_ready[0]=1 only in the 5th BUSY cycle.
- Granted thread2 switches to NONE mid-BUSY. Required: next cycle IDLE with grant_valid=0, rr_ptr=3, and no unit_ready forwarded to thread2.
- rst asserted during BUSY. Required: unit_sel=NONE, grant_valid=0 and all t_unit_ready for requesters =0 in the same cycle; after release the first grant goes to the lowest requester from rr_ptr=0.
